// File: rtl/oai33_arc_exerciser_pkg.sv
// Shared types and constants for the OAI33 timing-arc exerciser.
// Pin order is A1, A2, A3, B1, B2, B3, which is also the drive-vector MSB..LSB order.
package oai33_arc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      PH_LO0 = 2'd0,
      PH_HI  = 2'd1,
      PH_LO1 = 2'd2
   } phase_t;

   localparam int NUM_PINS = 6;
   localparam int NUM_COND = 7;
   localparam int NUM_ARCS = NUM_PINS * NUM_COND;

   localparam int PIN_A1 = 0;
   localparam int PIN_A2 = 1;
   localparam int PIN_A3 = 2;
   localparam int PIN_B1 = 3;
   localparam int PIN_B2 = 4;
   localparam int PIN_B3 = 5;

endpackage

// File: rtl/oai33_arc_exerciser_vector_gen.sv
// Combinational drive-vector builder for one arc phase of the OAI33 cell.
// vec = {A1, A2, A3, B1, B2, B3}; the side code goes to the group opposite the toggled pin.
module oai33_arc_vector_gen
   import oai33_arc_pkg::*;
(
   input  logic [2:0] pin,
   input  logic [2:0] cond,
   input  phase_t     phase,
   output logic [5:0] vec,
   output logic       zn_exp
);

   logic toggle;

   always_comb begin
      vec    = '0;
      toggle = (phase == PH_HI);
      if (pin < 3'(PIN_B1)) begin
         vec[2:0] = cond;
      end else begin
         vec[5:3] = cond;
      end
      vec[3'd5 - pin] = toggle;
      // Non-zero side code makes the toggled pin controlling, so ZN is its inverse.
      zn_exp = ~toggle;
   end

endmodule

// File: rtl/oai33_arc_exerciser.sv
// Walks all 42 sensitizable arcs of an OAI33 cell, drives its inputs and counts ZN mismatches.
// Optional first-failure capture: define OAI33_ARC_EXERCISER_FAIL_CAPTURE_EN.
module oai33_arc_exerciser
   import oai33_arc_pkg::*;
#(
   parameter int unsigned SETTLE = 2
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   input  logic       ZN_IN,
   output logic       A1,
   output logic       A2,
   output logic       A3,
   output logic       B1,
   output logic       B2,
   output logic       B3,
   output logic       BUSY,
   output logic       DONE,
   output logic       PASS,
   output logic [7:0] ERR_CNT,
   output logic [5:0] ARC_IDX,
   output logic [7:0] FIRST_FAIL
);

   state_t     state;
   phase_t     phase, nxt_phase, gen_phase;
   logic [2:0] pin, cond, nxt_pin, nxt_cond, gen_pin, gen_cond;
   logic [5:0] arc, drv, gen_vec;
   logic [3:0] cnt;
   logic [7:0] err;
   logic       exp_q, gen_exp, busy_q, done_q;
   logic       start_ok, sample, mismatch, last;

   assign start_ok = START && (state != ST_RUN);
   assign sample   = (state == ST_RUN) && (cnt == 4'd0);
   assign mismatch = (ZN_IN != exp_q);

   always_comb begin
      nxt_pin   = pin;
      nxt_cond  = cond;
      nxt_phase = phase;
      last      = 1'b0;
      case (phase)
         PH_LO0: nxt_phase = PH_HI;
         PH_HI:  nxt_phase = PH_LO1;
         default: begin
            nxt_phase = PH_LO0;
            if (arc == 6'(NUM_ARCS - 1)) begin
               last = 1'b1;
            end else if (cond == 3'(NUM_COND)) begin
               nxt_cond = 3'd1;
               nxt_pin  = pin + 3'd1;
            end else begin
               nxt_cond = cond + 3'd1;
            end
         end
      endcase
      gen_pin   = start_ok ? 3'd0 : nxt_pin;
      gen_cond  = start_ok ? 3'd1 : nxt_cond;
      gen_phase = start_ok ? PH_LO0 : nxt_phase;
   end

   oai33_arc_vector_gen u_vec (
      .pin    (gen_pin),
      .cond   (gen_cond),
      .phase  (gen_phase),
      .vec    (gen_vec),
      .zn_exp (gen_exp)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= ST_IDLE;
         phase  <= PH_LO0;
         pin    <= '0;
         cond   <= '0;
         arc    <= '0;
         cnt    <= '0;
         drv    <= '0;
         exp_q  <= 1'b0;
         err    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else if (start_ok) begin
         state  <= ST_RUN;
         phase  <= PH_LO0;
         pin    <= 3'd0;
         cond   <= 3'd1;
         arc    <= '0;
         cnt    <= 4'(SETTLE);
         drv    <= gen_vec;
         exp_q  <= gen_exp;
         err    <= '0;
         busy_q <= 1'b1;
         done_q <= 1'b0;
      end else if (sample) begin
         if (mismatch && (err != 8'hFF)) begin
            err <= err + 8'd1;
         end
         if (last) begin
            state  <= ST_DONE;
            drv    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
         end else begin
            phase <= nxt_phase;
            pin   <= nxt_pin;
            cond  <= nxt_cond;
            if (phase == PH_LO1) begin
               arc <= arc + 6'd1;
            end
            cnt   <= 4'(SETTLE);
            drv   <= gen_vec;
            exp_q <= gen_exp;
         end
      end else if (state == ST_RUN) begin
         cnt <= cnt - 4'd1;
      end
   end

`ifdef OAI33_ARC_EXERCISER_FAIL_CAPTURE_EN
   logic       ff_valid;
   phase_t     ff_phase;
   logic [5:0] ff_arc;

   always_ff @(posedge CLK) begin
      if (RST || start_ok) begin
         ff_valid <= 1'b0;
         ff_phase <= PH_LO0;
         ff_arc   <= '0;
      end else if (sample && mismatch && !ff_valid) begin
         ff_valid <= 1'b1;
         ff_phase <= phase;
         ff_arc   <= arc;
      end
   end

   // Only 5 arc bits fit in the output; the full index stays in ff_arc.
   assign FIRST_FAIL = {ff_valid, ff_phase, ff_arc[4:0]};
`else
   assign FIRST_FAIL = '0;
`endif

   assign {A1, A2, A3, B1, B2, B3} = drv;
   assign BUSY    = busy_q;
   assign DONE    = done_q;
   assign PASS    = done_q && (err == 8'd0);
   assign ERR_CNT = err;
   assign ARC_IDX = arc;

endmodule

// File: tb/tb_oai33_arc_exerciser.sv
// Directed bench: behavioural OAI33 with injectable faults driving the exerciser's ZN_IN.
module tb_oai33_arc_exerciser;

   logic       CLK = 1'b0;
   logic       RST, START, ZN_IN;
   logic       A1, A2, A3, B1, B2, B3;
   logic       BUSY, DONE, PASS;
   logic [7:0] ERR_CNT, FIRST_FAIL;
   logic [5:0] ARC_IDX;

   int checks   = 0;
   int failures = 0;
   int fault    = 0;   // 0 good, 1 ZN stuck 1, 2 ZN stuck 0, 3 B3 open

   oai33_arc_exerciser #(.SETTLE(2)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .START      (START),
      .ZN_IN      (ZN_IN),
      .A1         (A1),
      .A2         (A2),
      .A3         (A3),
      .B1         (B1),
      .B2         (B2),
      .B3         (B3),
      .BUSY       (BUSY),
      .DONE       (DONE),
      .PASS       (PASS),
      .ERR_CNT    (ERR_CNT),
      .ARC_IDX    (ARC_IDX),
      .FIRST_FAIL (FIRST_FAIL)
   );

   always #5 CLK = ~CLK;

   always_comb begin
      case (fault)
         1:       ZN_IN = 1'b1;
         2:       ZN_IN = 1'b0;
         3:       ZN_IN = ~((A1 | A2 | A3) & (B1 | B2));
         default: ZN_IN = ~((A1 | A2 | A3) & (B1 | B2 | B3));
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] ff_exp(input logic [7:0] v);
`ifdef OAI33_ARC_EXERCISER_FAIL_CAPTURE_EN
      return v;
`else
      return 8'h00 & v;
`endif
   endfunction

   task automatic pulse_start();
      START = 1'b1;
      @(posedge CLK);
      #1 START = 1'b0;
   endtask

   // Start a run, probe a few vectors, optionally pulse START mid-run, then check the result.
   task automatic run_to_done(input string tag, input int exp_err, input logic [7:0] exp_ff,
                              input int start_at);
      int n;
      pulse_start();
      n = 0;
      check({tag, "_busy0"}, BUSY, 1);
      check({tag, "_vec_lo0"}, {A1, A2, A3, B1, B2, B3}, 6'b000001);
      while (!DONE && n < 2000) begin
         @(posedge CLK);
         #1 n++;
         START = (n == start_at);
         if (n == 3)   check({tag, "_vec_hi"}, {A1, A2, A3, B1, B2, B3}, 6'b100001);
         if (n == 9)   check({tag, "_arc1"}, {ARC_IDX, A1, A2, A3, B1, B2, B3}, {6'd1, 6'b000010});
         if (n == 372) check({tag, "_arc41"}, {ARC_IDX, A1, A2, A3, B1, B2, B3}, {6'd41, 6'b111001});
      end
      START = 1'b0;
      check({tag, "_cycles"}, n, 378);
      check({tag, "_err"}, ERR_CNT, exp_err);
      check({tag, "_pass"}, PASS, (exp_err == 0));
      check({tag, "_first_fail"}, FIRST_FAIL, ff_exp(exp_ff));
      check({tag, "_idle_out"}, {BUSY, A1, A2, A3, B1, B2, B3}, 0);
   endtask

   initial begin
      RST   = 1'b1;
      START = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      check("reset_outs", {BUSY, DONE, PASS, ERR_CNT, ARC_IDX, FIRST_FAIL}, 0);
      check("reset_drv", {A1, A2, A3, B1, B2, B3}, 0);
      RST = 1'b0;
      @(posedge CLK);
      #1;

      fault = 0; run_to_done("good", 0, 8'h00, -1);
      fault = 1; run_to_done("stuck1", 42, 8'hA0, -1);
      fault = 2; run_to_done("stuck0", 84, 8'h80, -1);
      fault = 3; run_to_done("b3open", 10, 8'hA0, -1);

      // START at cycle 50 must be ignored; then a START in DONE clears the result.
      run_to_done("busy_start", 10, 8'hA0, 50);
      pulse_start();
      check("restart_clear", {DONE, BUSY, ERR_CNT, FIRST_FAIL}, {1'b0, 1'b1, 8'd0, 8'd0});

      // Mid-run reset after 100 cycles of a stuck-at-1 run.
      RST = 1'b1;
      @(posedge CLK);
      #1 RST = 1'b0;
      fault = 1;
      pulse_start();
      repeat (100) @(posedge CLK);
      #1;
      check("pre_rst_err", ERR_CNT, 11);
      check("pre_rst_arc", ARC_IDX, 11);
      RST = 1'b1;
      @(posedge CLK);
      #1 RST = 1'b0;
      check("rst_mid", {BUSY, DONE, ERR_CNT, ARC_IDX, FIRST_FAIL, A1, A2, A3, B1, B2, B3}, 0);
      run_to_done("after_rst", 42, 8'hA0, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/oai33_arc_exerciser.md
# oai33_arc_exerciser

- Sequential stimulus and response checker for the OAI33 cell: ZN = !((A1|A2|A3) & (B1|B2|B3)).
- Walks every sensitizable conditional timing arc of the cell, drives the six inputs, samples ZN and counts mismatches.
- It is the driving and reading side of the cell's arc definitions, and sits in the library's silicon and characterization test harness, clocked alongside the cell instance under test.

## Interface
- SETTLE, default 2: cycles each drive vector is held before ZN is sampled on the following cycle; legal range 1..15.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  single-cycle pulse that begins a run; honoured only in IDLE or DONE.
- ZN_IN  in  1  output of the cell under test.
- A1, A2, A3, B1, B2, B3  out  1 each  registered drives to the cell inputs.
- BUSY  out  1  high while a run is in progress.
- DONE  out  1  sticky high after a run completes; cleared by START or RST.
- PASS  out  1  valid when DONE is high; 1 iff ERR_CNT == 0.
- ERR_CNT  out  8  saturating mismatch count.
- ARC_IDX  out  6  index of the current arc, 0..41.
- FIRST_FAIL  out  8  {valid, phase[1:0], arc[5:0] truncated to 5 bits of arc}; see Configuration.

## Operation
- **Arc ordering.**
  - Toggled pin p runs 0..5 in the order A1, A2, A3, B1, B2, B3.
  - Side condition c runs 1..7 as the 3-bit code applied to the opposite group's pins, MSB = pin1.
  - The unused pins of the toggled pin's own group are held 0.
  - ARC_IDX = p*7 + (c-1); 42 arcs in total.
  - Side code 000 (the ifnone arc) is not sensitizable and is skipped.
- **Phases per arc.** Each phase drives its vector for SETTLE cycles, then samples ZN_IN on the next cycle.
  - LO0: pin = 0, expected ZN = 1.
  - HI: pin = 1, expected ZN = 0.
  - LO1: pin = 0, expected ZN = 1.
- **Mismatch.** ZN_IN != expected at the sample cycle increments ERR_CNT, saturating at 255.
- **FSM.**
  - IDLE → (START) RUN.
  - RUN steps through phase and settle counters, then advances the arc.
  - After the LO1 sample of arc 41 → DONE.
  - DONE → (START) RUN.
- **START.**
  - Starting a run clears ERR_CNT, ARC_IDX and FIRST_FAIL.
  - START while BUSY is ignored.
- **Drives.** All drives are 0 in IDLE and DONE.
- **Reset values.** All outputs 0. RST mid-run returns to IDLE on the next edge, with drives 0 and counters cleared.
- **Simultaneous events.** RST has priority over START.

## Timing
- Drive vectors are registered and change on the edge that starts a phase.
- The sample is taken at cycle SETTLE+1 of the phase, so each phase lasts SETTLE+1 cycles.
- Run length: 42*3*(SETTLE+1) cycles from the first RUN cycle; 378 cycles at SETTLE=2.
- BUSY rises on the edge after START. DONE rises, and BUSY falls, on the edge after the final sample.
- ARC_IDX updates together with the LO0 drives of each new arc.
- ERR_CNT updates on the edge after the sample cycle.
- There is no combinational path from ZN_IN to any output.

## Configuration
- Macro: OAI33_ARC_EXERCISER_FAIL_CAPTURE_EN.
- **Defined.** FIRST_FAIL latches {1'b1, phase, ARC_IDX[4:0]} on the first mismatch of a run and holds it until START or RST. Phase encoding: LO0 = 0, HI = 1, LO1 = 2. The full ARC_IDX is also latched internally.
- **Undefined.** FIRST_FAIL is tied to 0 and the capture logic is absent.
- Every other behaviour is identical in both builds.

## Structure
- Package oai33_arc_pkg contains:
  - the FSM state enum (IDLE, RUN, DONE);
  - the phase enum (LO0, HI, LO1);
  - NUM_PINS = 6, NUM_COND = 7, NUM_ARCS = 42;
  - the pin index constants.
- Sub-module oai33_arc_vector_gen is purely combinational:
  - inputs: pin, cond, phase;
  - outputs: the 6-bit drive vector and the expected ZN.
- The top level holds the FSM, counters, error and capture registers.

## Test plan
- **Correct cell.** Behavioural OAI33 connected, SETTLE=2, START pulse → DONE at 378 cycles, ERR_CNT=0, PASS=1.
- **ZN stuck at 1.** → ERR_CNT=42 (every HI phase), PASS=0. With the capture macro, FIRST_FAIL = {1, HI, 0}.
- **ZN stuck at 0.** → ERR_CNT=84 (every LO0 and LO1 phase). FIRST_FAIL phase = LO0, arc 0.
- **B3 input open (reads 0) in the model.**
  - 3 A-pin arcs with side code 001 fail in HI.
  - 7 B3-pin arcs fail in HI.
  - Result: ERR_CNT=10, FIRST_FAIL arc 0.
- **RST mid-run.** RST at cycle 100 → next edge: drives 0, BUSY=0, ERR_CNT=0. A later START → full 378-cycle run.
- **START while BUSY.** START pulsed at cycle 50 of a run → ignored; DONE still arrives at cycle 378. A second START in DONE clears DONE and ERR_CNT.
